instr_stream_encoder: RTL
=========================

// Module: instr_stream_encoder
// PURPOSE
//  Encodes RV32I control-class requests (R, I-ALU, LOAD, STORE, BRANCH) into 32-bit
//  instruction words and writes them sequentially into instruction memory.
//  It is the inverse of the core's opcode decoder: field-level requests go in,
//  machine words come out. Used for boot/self-test program loading ahead of IF.
// PARAMETERS
//  ADDR_W      10    imem word-address width
//  BASE_ADDR   0     first word address written after start
//  IMEM_DEPTH  1024  number of writable words; last legal address = BASE_ADDR+IMEM_DEPTH-1
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       1-cycle pulse: clear pointer/count/err, enter RUN
//  req_valid   in   1       request valid
//  req_ready   out  1       request accepted on edge where valid&ready
//  req_class   in   3       0=R 1=I-ALU 2=LOAD 3=STORE 4=BRANCH 5=END 6,7=illegal
//  rd/rs1/rs2  in   5 each  register fields
//  funct3      in   3       funct3 field
//  funct7      in   7       funct7 (R only)
//  imm         in   13      signed immediate, byte offset for BRANCH
//  imem_we     out  1       write strobe, 1 cycle per word
//  imem_addr   out  ADDR_W  word address
//  imem_wdata  out  32      encoded instruction
//  busy        out  1       state==RUN
//  done        out  1       state==DONE (level)
//  err         out  1       state==ERR (level)
//  err_code    out  2       1=imm range/alignment, 2=overflow, 3=illegal class
//  count       out  ADDR_W+1 words written since start
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; pointer=BASE_ADDR. Reset mid-write drops the word.
//  - FSM: IDLE -start-> RUN; RUN -END accepted-> DONE; RUN -bad req-> ERR;
//    DONE/ERR -start-> RUN. A start in any state restarts (pointer=BASE_ADDR, count=0, err_code=0).
//  - req_ready = (state==RUN) & ~start; start wins over a simultaneous request.
//  - Latency 1: request accepted at edge N -> imem_we=1 with addr/wdata registered
//    for the cycle after N; pointer and count increment at that same edge.
//  - Encodings (opcode in [6:0]):
//    R      {funct7,rs2,rs1,funct3,rd,0110011}
//    I-ALU  {imm[11:0],rs1,funct3,rd,0010011}; LOAD same with 0000011
//    STORE  {imm[11:5],rs2,rs1,funct3,imm[4:0],0100011}
//    BRANCH {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],1100011}
//  - Checks on accept (priority: illegal class, imm, overflow); a failing request writes nothing:
//    I/LOAD/STORE: imm[12]!=imm[11] -> code 1. BRANCH: imm[0]=1 -> code 1.
//    Any write when count==IMEM_DEPTH -> code 2 (last legal word is still written).
//    class 6/7 -> code 3. R ignores imm. Other classes ignore funct7.
//  - END: accepted, no write, -> DONE. count holds the final value until the next start.
//  - Requests in IDLE/DONE/ERR are not accepted (req_ready=0).
// TESTING
//  1. start; R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> next cycle we=1 addr=0 wdata=0x002081B3, count=1
//  2. I-ALU rd=1 rs1=0 imm=5 then LOAD rd=5 rs1=2 f3=2 imm=8 back-to-back -> 0x00500093 @0,
//     0x00812283 @1, with no bubble
//  3. STORE rs1=2 rs2=5 f3=2 imm=12 -> 0x00512623; BRANCH rs1=1 rs2=2 f3=0 imm=-8 -> 0xFE208CE3
//  4. I-ALU imm=0x800 (+2048) -> no write, err=1, code=1, req_ready=0; start -> RUN, err=0
//  5. IMEM_DEPTH=4: 4 writes succeed, 5th -> err code 2, no we; END after 3 -> done=1, count=3
//  6. start asserted with req_valid in RUN -> request not taken, addr restarts at BASE_ADDR;
//     rst_n low mid-stream -> all outputs 0 asynchronously

Source files
------------

// File: rtl/instr_stream_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_stream_encoder_if
//   Bundles the request handshake and the instruction-memory write bus of the
//   instruction stream encoder.
//
//   Request side (master drives, encoder consumes):
//     req_valid   request valid
//     req_ready   encoder can accept this cycle
//     req_class   0=R 1=I-ALU 2=LOAD 3=STORE 4=BRANCH 5=END 6,7=illegal
//     rd/rs1/rs2  register fields
//     funct3      funct3 field
//     funct7      funct7 field (R only)
//     imm         13-bit signed immediate (byte offset for BRANCH)
//   Memory side (encoder drives):
//     imem_we     one-cycle write strobe per word
//     imem_addr   word address
//     imem_wdata  encoded instruction word
// -----------------------------------------------------------------------------
interface instr_stream_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_class;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [12:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Request producer / write-bus observer (program loader or testbench).
    modport master (
        output req_valid, req_class, rd, rs1, rs2, funct3, funct7, imm,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    // The encoder itself.
    modport slave (
        input  req_valid, req_class, rd, rs1, rs2, funct3, funct7, imm,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// -----------------------------------------------------------------------------
// instr_stream_encoder
//   Turns field-level RV32I requests (R, I-ALU, LOAD, STORE, BRANCH) into
//   32-bit machine words and writes them to consecutive instruction-memory
//   words starting at BASE_ADDR. Used to load boot / self-test programs.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     start     one-cycle pulse: clear pointer/count/err_code, enter RUN
//     bus       request handshake + imem write bus (slave modport)
//     busy      state == RUN
//     done      state == DONE (level)
//     err       state == ERR (level)
//     err_code  1 = imm range/alignment, 2 = overflow, 3 = illegal class
//     count     words written since the last start
//
//   Timing: a request accepted on edge N produces imem_we/addr/wdata during
//   the cycle after N; pointer and count advance on that same edge, so
//   back-to-back requests stream without bubbles.
// -----------------------------------------------------------------------------
module instr_stream_encoder #(
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    instr_stream_encoder_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ADDR_W:0]      count
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [2:0] C_R      = 3'd0;
    localparam logic [2:0] C_IALU   = 3'd1;
    localparam logic [2:0] C_LOAD   = 3'd2;
    localparam logic [2:0] C_STORE  = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_END    = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] E_IMM      = 2'd1;
    localparam logic [1:0] E_OVERFLOW = 2'd2;
    localparam logic [1:0] E_ILLEGAL  = 2'd3;

    localparam logic [ADDR_W-1:0] BASE_PTR = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   DEPTH    = IMEM_DEPTH[ADDR_W:0];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_err_code;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic        w_ready;
    logic        w_accept;
    logic        w_is_end;
    logic        w_illegal;
    logic        w_imm_bad;
    logic        w_full;
    logic [31:0] w_word;

    // A start pulse owns the cycle: the request waits for the new run.
    assign w_ready  = (r_state == S_RUN) && !start;
    assign w_accept = bus.req_valid && w_ready;

    assign w_is_end  = (bus.req_class == C_END);
    assign w_illegal = (bus.req_class[2:1] == 2'b11);
    // The last legal word is still written; only a write past it overflows.
    assign w_full    = (r_count == DEPTH);

    // Immediate legality: 12-bit fields must be a sign extension of bit 11;
    // branch offsets must be halfword aligned. R ignores imm entirely.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_imm_bad = 1'b0;
        case (bus.req_class)
            C_IALU, C_LOAD, C_STORE: w_imm_bad = bus.imm[12] ^ bus.imm[11];
            C_BRANCH:                w_imm_bad = bus.imm[0];
            default:                 w_imm_bad = 1'b0;
        endcase
    end

    // Instruction formats. funct7 only appears in the R format.
    always_comb begin
        w_word = 32'd0;
        case (bus.req_class)
            C_R:
                w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
            C_IALU:
                w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_IALU};
            C_LOAD:
                w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_LOAD};
            C_STORE:
                w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                          bus.imm[4:0], OP_STORE};
            C_BRANCH:
                w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                          bus.imm[4:1], bus.imm[11], OP_BRANCH};
            default:
                w_word = 32'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM, write pointer and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and evaluation order does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= BASE_PTR;
            r_count    <= '0;
            r_err_code <= 2'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
        end else begin
            // Write strobe is a single-cycle pulse; addr/wdata hold their value.
            r_we <= 1'b0;

            if (start) begin
                r_state    <= S_RUN;
                r_ptr      <= BASE_PTR;
                r_count    <= '0;
                r_err_code <= 2'd0;
            end else if (w_accept) begin
                // Checks in priority order; any failure writes nothing.
                if (w_is_end) begin
                    r_state <= S_DONE;
                end else if (w_illegal) begin
                    r_state    <= S_ERR;
                    r_err_code <= E_ILLEGAL;
                end else if (w_imm_bad) begin
                    r_state    <= S_ERR;
                    r_err_code <= E_IMM;
                end else if (w_full) begin
                    r_state    <= S_ERR;
                    r_err_code <= E_OVERFLOW;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= r_ptr;
                    r_wdata <= w_word;
                    r_ptr   <= r_ptr + 1'b1;
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req_ready  = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign err      = (r_state == S_ERR);
    assign err_code = r_err_code;
    assign count    = r_count;

endmodule
